retardo_var: RTL

RETARDO_VAR -- requirements
Module: retardo_var

---
 rtl/retardo_var_pkg.sv | 20 ++
 rtl/retardo_var_if.sv | 39 +++
 rtl/retardo_var_reg.sv | 20 ++
 rtl/retardo_var.sv | 95 +++++++++
 4 files changed

// File: rtl/retardo_var_pkg.sv
// Shared defaults and constant helpers for the variable-delay line.
package retardo_var_pkg;

  localparam int unsigned DEF_WIDTH_DATA = 8;
  localparam int unsigned DEF_MAX_DELAY  = 16;

  // Ceiling log2, never below 1 so that degenerate sizes still get a legal vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/retardo_var_if.sv
// Sample/delay-control bundle between a stream source and the variable-delay line.
interface retardo_var_if
  import retardo_var_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int unsigned MAX_DELAY  = DEF_MAX_DELAY
);

    localparam int unsigned DSEL_W = clog2(MAX_DELAY + 1);

    logic                  enable;
    logic [WIDTH_DATA-1:0] data_in;
    logic [DSEL_W-1:0]     delay_sel;
    logic                  delay_load;
    logic [WIDTH_DATA-1:0] data_out;
    logic                  valid_out;
    logic [DSEL_W-1:0]     delay_act;

    modport master (
        output enable,
        output data_in,
        output delay_sel,
        output delay_load,
        input  data_out,
        input  valid_out,
        input  delay_act
    );

    modport slave (
        input  enable,
        input  data_in,
        input  delay_sel,
        input  delay_load,
        output data_out,
        output valid_out,
        output delay_act
    );

endinterface

// File: rtl/retardo_var_reg.sv
// Enabled storage register with asynchronous clear; one instance per delay-line entry.
module retardo_var_reg #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/retardo_var.sv
// Variable-length delay line: circular buffer written once per enabled edge,
// read combinationally delay_act samples behind the write pointer.
module retardo_var
  import retardo_var_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int unsigned MAX_DELAY  = DEF_MAX_DELAY
) (
    input logic         clk,
    input logic         reset,
    retardo_var_if.slave bus
);

    localparam int unsigned PTR_W  = clog2(MAX_DELAY);
    localparam int unsigned DSEL_W = clog2(MAX_DELAY + 1);
    // One extra bit so wr_ptr + MAX_DELAY - delay_act never overflows.
    localparam int unsigned SUM_W  = DSEL_W + 1;

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(MAX_DELAY - 1);
    localparam logic [DSEL_W-1:0] MAX_D     = DSEL_W'(MAX_DELAY);
    localparam logic [DSEL_W-1:0] MIN_D     = DSEL_W'(1);
    localparam logic [SUM_W-1:0]  MAX_D_SUM = SUM_W'(MAX_DELAY);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DSEL_W-1:0]     fill_q, fill_d;
    logic [DSEL_W-1:0]     delay_act_q, delay_act_d;
    logic [WIDTH_DATA-1:0] mem_q [MAX_DELAY];

    logic [SUM_W-1:0]      rd_sum;
    logic [SUM_W-1:0]      rd_wrap;
    logic [PTR_W-1:0]      rd_idx;

    for (genvar i = 0; i < MAX_DELAY; i++) begin : g_mem
        logic en;
        assign en = bus.enable && (wr_ptr_q == PTR_W'(i));

        retardo_var_reg #(
            .N(WIDTH_DATA)
        ) u_reg (
            .clk(clk),
            .clr(reset),
            .en (en),
            .d  (bus.data_in),
            .q  (mem_q[i])
        );
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (bus.enable) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (fill_q < MAX_D) begin
                fill_d = fill_q + DSEL_W'(1);
            end
        end
    end

    always_comb begin
        delay_act_d = delay_act_q;
        if (bus.delay_load) begin
            if (bus.delay_sel == '0) begin
                delay_act_d = MIN_D;
            end else if (bus.delay_sel > MAX_D) begin
                delay_act_d = MAX_D;
            end else begin
                delay_act_d = bus.delay_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            delay_act_q <= MAX_D;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            delay_act_q <= delay_act_d;
        end
    end

    // delay_act is always in 1..MAX_DELAY, so a single conditional subtract wraps the index.
    always_comb begin
        rd_sum  = SUM_W'(wr_ptr_q) + MAX_D_SUM - SUM_W'(delay_act_q);
        rd_wrap = (rd_sum >= MAX_D_SUM) ? rd_sum - MAX_D_SUM : rd_sum;
        rd_idx  = PTR_W'(rd_wrap);
    end

    assign bus.data_out  = mem_q[rd_idx];
    assign bus.valid_out = (fill_q >= delay_act_q);
    assign bus.delay_act = delay_act_q;

endmodule
